// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment encodings, readback FSM states and the pattern decode helper
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] BIT_A = 7'(1 << SEG_A);
  localparam logic [6:0] BIT_B = 7'(1 << SEG_B);
  localparam logic [6:0] BIT_C = 7'(1 << SEG_C);
  localparam logic [6:0] BIT_D = 7'(1 << SEG_D);
  localparam logic [6:0] BIT_E = 7'(1 << SEG_E);
  localparam logic [6:0] BIT_F = 7'(1 << SEG_F);
  localparam logic [6:0] BIT_G = 7'(1 << SEG_G);

  localparam logic [6:0] SEG_0     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F;
  localparam logic [6:0] SEG_1     = BIT_B | BIT_C;
  localparam logic [6:0] SEG_2     = BIT_A | BIT_B | BIT_D | BIT_E | BIT_G;
  localparam logic [6:0] SEG_3     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_G;
  localparam logic [6:0] SEG_4     = BIT_B | BIT_C | BIT_F | BIT_G;
  localparam logic [6:0] SEG_5     = BIT_A | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [6:0] SEG_6     = BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] SEG_7     = BIT_A | BIT_B | BIT_C;
  localparam logic [6:0] SEG_8     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] SEG_9     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } seg_state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t d;
    d.legal = 1'b1;
    d.blank = 1'b0;
    d.digit = 4'd0;
    case (pat)
      SEG_0:     d.digit = 4'd0;
      SEG_1:     d.digit = 4'd1;
      SEG_2:     d.digit = 4'd2;
      SEG_3:     d.digit = 4'd3;
      SEG_4:     d.digit = 4'd4;
      SEG_5:     d.digit = 4'd5;
      SEG_6:     d.digit = 4'd6;
      SEG_7:     d.digit = 4'd7;
      SEG_8:     d.digit = 4'd8;
      SEG_9:     d.digit = 4'd9;
      SEG_BLANK: begin
        d.legal = 1'b0;
        d.blank = 1'b1;
      end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] inc10(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dec10(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/seg_filter.sv
// rtl/seg_filter.sv - input register plus stability filter; SEG_READBACK_HOLDCHK_EN exposes the abandon strobe
module seg_filter import seg_pkg::*; #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  output logic       accept,
  output logic [6:0] acc_pat
`ifdef SEG_READBACK_HOLDCHK_EN
  ,
  output logic       abandon
`endif
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic [6:0] cand;
  logic [6:0] last_acc;
  logic [7:0] run;
  logic       load;

  assign load    = (seg_q != cand);
  assign acc_pat = load ? seg_q : cand;

  // run saturates at RUN_MAX, so the RUN_MAX-1 -> RUN_MAX step happens once per candidate
  assign accept = (load ? (RUN_MAX == 8'd1) : (run == RUN_MAX - 8'd1))
                  && (acc_pat != last_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= SEG_BLANK;
      cand     <= SEG_BLANK;
      last_acc <= SEG_BLANK;
      run      <= 8'd0;
    end else begin
      seg_q <= seg;
      if (load) begin
        cand <= seg_q;
        run  <= 8'd1;
      end else if (run != RUN_MAX) begin
        run <= run + 8'd1;
      end
      if (accept) begin
        last_acc <= acc_pat;
      end
    end
  end

`ifdef SEG_READBACK_HOLDCHK_EN
  assign abandon = load && (run != RUN_MAX) && (cand != last_acc);
`endif

endmodule

// File: rtl/seg_readback.sv
// rtl/seg_readback.sv - 7-segment readback decoder and step classifier
// SEG_READBACK_HOLDCHK_EN adds hold_err and glitch_cnt for abandoned candidates.
module seg_readback import seg_pkg::*; #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             step_up,
  output logic             step_down,
  output logic             step_jump,
  output logic             err_invalid,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt
`ifdef SEG_READBACK_HOLDCHK_EN
  ,
  output logic             hold_err,
  output logic [7:0]       glitch_cnt
`endif
);

  logic       accept;
  logic [6:0] acc_pat;
  seg_dec_t   dec;
  seg_state_t state, state_n;

  logic [3:0]       digit_n;
  logic             digit_valid_n, blank_n;
  logic             up_n, down_n, jump_n, err_n;
  logic [CNT_W-1:0] up_cnt_n, down_cnt_n;

`ifdef SEG_READBACK_HOLDCHK_EN
  logic abandon;

  seg_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .accept  (accept),
    .acc_pat (acc_pat),
    .abandon (abandon)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_err   <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      hold_err <= abandon;
      if (abandon && (glitch_cnt != 8'hFF)) begin
        glitch_cnt <= glitch_cnt + 8'd1;
      end
    end
  end
`else
  seg_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .accept  (accept),
    .acc_pat (acc_pat)
  );
`endif

  assign dec = seg_decode(acc_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      step_jump   <= 1'b0;
      err_invalid <= 1'b0;
      up_cnt      <= '0;
      down_cnt    <= '0;
    end else begin
      state       <= state_n;
      digit       <= digit_n;
      digit_valid <= digit_valid_n;
      blank       <= blank_n;
      step_up     <= up_n;
      step_down   <= down_n;
      step_jump   <= jump_n;
      err_invalid <= err_n;
      up_cnt      <= up_cnt_n;
      down_cnt    <= down_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    if (accept) begin
      if (dec.blank)      state_n = EMPTY;
      else if (dec.legal) state_n = TRACK;
      else                state_n = FAULT;
    end
  end

  // Only TRACK holds a trustworthy previous digit, so only TRACK classifies steps
  always_comb begin
    digit_n       = digit;
    digit_valid_n = digit_valid;
    blank_n       = blank;
    up_n          = 1'b0;
    down_n        = 1'b0;
    jump_n        = 1'b0;
    err_n         = 1'b0;
    up_cnt_n      = up_cnt;
    down_cnt_n    = down_cnt;
    if (accept) begin
      digit_valid_n = dec.legal;
      blank_n       = dec.blank;
      err_n         = !dec.legal && !dec.blank;
      if (dec.legal) begin
        digit_n = dec.digit;
        if (state == TRACK) begin
          if (dec.digit == inc10(digit)) begin
            up_n     = 1'b1;
            up_cnt_n = up_cnt + CNT_W'(1);
          end else if (dec.digit == dec10(digit)) begin
            down_n     = 1'b1;
            down_cnt_n = down_cnt + CNT_W'(1);
          end else begin
            jump_n = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_readback.sv
// tb/tb_seg_readback.sv - self-checking bench for seg_readback against a sample-window model
// SEG_READBACK_HOLDCHK_EN also checks hold_err and glitch_cnt.
module tb_seg_readback;

  localparam int S  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg = 7'h00;
  logic [3:0]    digit;
  logic          digit_valid, blank, step_up, step_down, step_jump, err_invalid;
  logic [CW-1:0] up_cnt, down_cnt;
`ifdef SEG_READBACK_HOLDCHK_EN
  logic          hold_err;
  logic [7:0]    glitch_cnt;
`endif

  always #5 clk = ~clk;

  seg_readback #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .step_up     (step_up),
    .step_down   (step_down),
    .step_jump   (step_jump),
    .err_invalid (err_invalid),
    .up_cnt      (up_cnt),
    .down_cnt    (down_cnt)
`ifdef SEG_READBACK_HOLDCHK_EN
    ,
    .hold_err    (hold_err),
    .glitch_cnt  (glitch_cnt)
`endif
  );

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_pass  = 0;
  int n_total = 0;

  // model: samples since reset, last accepted pattern and expected outputs
  logic [6:0] hist [$];
  logic [6:0] m_last;
  logic [3:0] m_digit;
  logic       m_dv, m_blank, m_up, m_down, m_jump, m_err;
  logic [7:0] m_upc, m_dnc;
  logic       m_hold;
  logic [7:0] m_glc;
  bit         m_live = 1'b0;

  function automatic int find_digit(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (pats[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    int         sz, d, pd, len;
    bit         acc;
    logic [6:0] p;
    if (rst) begin
      hist.delete();
      hist.push_back(7'h00);
      m_last = 7'h00; m_digit = 4'd0; m_dv = 1'b0; m_blank = 1'b0;
      m_up = 1'b0; m_down = 1'b0; m_jump = 1'b0; m_err = 1'b0;
      m_upc = 8'd0; m_dnc = 8'd0; m_hold = 1'b0; m_glc = 8'd0;
      m_live = 1'b1;
    end else if (m_live) begin
      sz = hist.size();
      m_up = 1'b0; m_down = 1'b0; m_jump = 1'b0; m_err = 1'b0; m_hold = 1'b0;
      // a differing candidate that changed before S identical samples is a glitch
      if (sz >= 2 && hist[sz-1] != hist[sz-2] && hist[sz-2] != m_last) begin
        len = 0;
        for (int i = sz - 2; i >= 0; i--) begin
          if (hist[i] != hist[sz-2]) break;
          len++;
        end
        if (len < S) begin
          m_hold = 1'b1;
          if (m_glc != 8'hFF) m_glc = m_glc + 8'd1;
        end
      end
      acc = 1'b0;
      p   = 7'h00;
      if (sz >= S) begin
        p   = hist[sz-1];
        acc = 1'b1;
        for (int i = sz - S; i < sz; i++) if (hist[i] != p) acc = 1'b0;
        if (sz > S && hist[sz-S-1] == p) acc = 1'b0;
        if (p == m_last) acc = 1'b0;
      end
      if (acc) begin
        m_last = p;
        d = find_digit(p);
        if (p == 7'h00) begin
          m_dv = 1'b0; m_blank = 1'b1;
        end else if (d < 0) begin
          m_dv = 1'b0; m_blank = 1'b0; m_err = 1'b1;
        end else begin
          if (m_dv) begin
            pd = int'(m_digit);
            if (d == (pd + 1) % 10) begin
              m_up = 1'b1; m_upc = m_upc + 8'd1;
            end else if (d == (pd + 9) % 10) begin
              m_down = 1'b1; m_dnc = m_dnc + 8'd1;
            end else begin
              m_jump = 1'b1;
            end
          end
          m_digit = 4'(d); m_dv = 1'b1; m_blank = 1'b0;
        end
      end
      hist.push_back(seg);
      if (hist.size() > S + 2) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cycle", {digit, digit_valid, blank, step_up, step_down, step_jump, err_invalid, up_cnt, down_cnt},
                     {m_digit, m_dv, m_blank, m_up, m_down, m_jump, m_err, m_upc, m_dnc});
`ifdef SEG_READBACK_HOLDCHK_EN
      check("hold", {hold_err, glitch_cnt}, {m_hold, m_glc});
`endif
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         r;
    int         n;
    logic [6:0] p;
    rst = 1'b1;
    seg = 7'h00;
    repeat (3) @(negedge clk);

    rst = 1'b0;
    seg = 7'h3F;
    repeat (4) @(negedge clk);
    check("t1_dv_early", digit_valid, 1'b0);
    check("t1_model_dv_early", m_dv, 1'b0);
    @(negedge clk);
    check("t1_dv", digit_valid, 1'b1);
    check("t1_digit", digit, 4'd0);
    check("t1_up_cnt", up_cnt, 8'd0);
    check("t1_model_dv", m_dv, 1'b1);
    repeat (5) @(negedge clk);

    hold(7'h06, 10);
    hold(7'h5B, 10);
    check("t2_digit", digit, 4'd2);
    check("t2_up_cnt", up_cnt, 8'd2);
    check("t2_model_upc", m_upc, 8'd2);

    hold(7'h3F, 10);
    hold(7'h6F, 10);
    check("t3_digit", digit, 4'd9);
    check("t3_down_cnt", down_cnt, 8'd1);
    hold(7'h3F, 10);
    check("t3_wrap_digit", digit, 4'd0);
    check("t3_wrap_up_cnt", up_cnt, 8'd3);
    check("t3_model_upc", m_upc, 8'd3);

    hold(7'h06, 10);
    hold(7'h7F, 2);
    hold(7'h06, 10);
    check("t4_digit", digit, 4'd1);
    check("t4_up_cnt", up_cnt, 8'd4);
`ifdef SEG_READBACK_HOLDCHK_EN
    check("t4_glitch_cnt", glitch_cnt, 8'd1);
    check("t4_model_glc", m_glc, 8'd1);
`endif

    hold(7'h01, 10);
    check("t5_dv", digit_valid, 1'b0);
    check("t5_digit_held", digit, 4'd1);
    hold(7'h66, 10);
    check("t5_digit", digit, 4'd4);
    check("t5_dv_back", digit_valid, 1'b1);
    check("t5_counts", {up_cnt, down_cnt}, 16'h0401);
    check("t5_model_counts", {m_upc, m_dnc}, 16'h0401);

    hold(7'h06, 10);
    hold(7'h5B, 2);
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_outs", {digit, digit_valid, blank, step_up, step_down, step_jump, err_invalid, up_cnt, down_cnt}, 26'd0);
    rst = 1'b0;
    hold(7'h5B, 10);
    check("t6_digit", digit, 4'd2);
    check("t6_dv", digit_valid, 1'b1);
    check("t6_up_cnt", up_cnt, 8'd0);

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 15);
      if (r < 10)      p = pats[r];
      else if (r == 10) p = 7'h00;
      else if (r < 14)  p = 7'($urandom);
      else              p = seg;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      n = $urandom_range(1, 8);
      hold(p, n);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_readback.md
Name: seg_readback

Overview:
- Receive-side decoder for the 7-segment click counter's display lines.
- Samples the seven active-high segment lines, rejects glitches, and decodes the pattern back to a BCD digit.
- Infers each display step as up (+1 mod 10), down (−1 mod 10) or jump, and flags illegal patterns.
- Used as a scoreboard front-end in benches and as an on-chip display self-check.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted (legal range 1..255).
- CNT_W, 8: width of the step counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- seg  input  7  segment lines: seg[0]=a=out1, seg[1]=b=out2, …, seg[6]=g=out7; 1 = lit.
- digit  output  4  last accepted decoded digit, 0..9.
- digit_valid  output  1  digit holds a legal accepted value.
- blank  output  1  last accepted pattern was all-off (7'h00).
- step_up  output  1  one-cycle pulse: accepted digit = previous + 1 mod 10.
- step_down  output  1  one-cycle pulse: accepted digit = previous − 1 mod 10.
- step_jump  output  1  one-cycle pulse: accepted legal digit is neither ±1 from previous.
- err_invalid  output  1  one-cycle pulse: accepted pattern is neither a digit nor blank.
- up_cnt  output  CNT_W  number of step_up events, wraps.
- down_cnt  output  CNT_W  number of step_down events, wraps.

Behaviour:
- Reset values: all outputs 0; state EMPTY; internal sample, candidate and run counter cleared.
- Input stage: seg registered once into seg_q every cycle (no other synchronisation).
- Stability filter:
  - If seg_q differs from the candidate, load seg_q as the new candidate and set run = 1.
  - Otherwise run increments and saturates at STABLE_CYCLES.
  - Acceptance fires in the cycle run first reaches STABLE_CYCLES and the candidate differs from the last accepted pattern.
  - A pattern applied before edge k, held steady, updates outputs at edge k+STABLE_CYCLES.
  - Re-presenting the same pattern after a glitch shorter than STABLE_CYCLES causes no event.
- Decode table (seg hex → digit):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00 → blank.
  - Anything else → invalid.
- FSM states: EMPTY (no legal previous digit), TRACK (legal previous digit held), FAULT (last accept was invalid). On acceptance:
  - Legal digit from EMPTY or FAULT → TRACK. digit/digit_valid update; no step pulse.
  - Legal digit from TRACK → classify against the previous digit:
    - 9→0 is up; 0→9 is down.
    - Same digit cannot occur, because acceptance requires a changed pattern.
    - Fire exactly one of step_up, step_down or step_jump.
  - Blank → EMPTY. digit_valid = 0, blank = 1, digit holds its old value; no pulse.
  - Invalid → FAULT. err_invalid pulses, digit_valid = 0, blank = 0.
- Counters: up_cnt/down_cnt increment in the same cycle as their pulse and wrap at 2^CNT_W.
- Pulse width: all pulses are exactly one cycle and mutually exclusive.
- Reset asserted mid-filter: discards the candidate and returns to EMPTY on that edge.
- The first acceptance after reset never produces a step pulse.

Optional Feature:
- Macro SEG_READBACK_HOLDCHK_EN.
- When defined:
  - Adds output hold_err (1 bit, reset 0).
  - hold_err pulses when a candidate that differs from the last accepted pattern is abandoned before reaching STABLE_CYCLES, i.e. a glitch or partial update.
  - Adds a saturating 8-bit glitch_cnt output.
- When undefined: neither port exists and the filter logic is unchanged.

Decomposition:
- Shared package seg_pkg holds:
  - localparams for the ten digit patterns and SEG_BLANK.
  - the segment index constants A..G.
  - the FSM state encoding (EMPTY=0, TRACK=1, FAULT=2).
- Natural sub-module seg_filter: input register, candidate register and run counter, producing the accept strobe and the accepted pattern.
- Decode and classification stay in seg_readback.

Test Plan:
- Reset then hold seg=7'h3F for 6 cycles (STABLE_CYCLES=4) → digit=0, digit_valid=1 exactly 4 edges after first presentation; no step pulse; up_cnt=0.
- Sequence 3F→06→5B, each held 10 cycles → two step_up pulses; up_cnt=2; digit=2.
- From 0 (3F) apply 6F held 10 cycles → step_down once; digit=9. Then 3F → step_up (9→0 wrap).
- From 1 (06) apply 7F for 2 cycles, then 06 again → no pulse, digit stays 1; with SEG_READBACK_HOLDCHK_EN, hold_err pulses once.
- Apply 7'h01 held 10 cycles → err_invalid pulses once, digit_valid=0. Then 66 → digit=4, digit_valid=1, no step pulse.
- Assert rst for 1 cycle midway through a 5B run while TRACK at 1 → all outputs 0; following 5B accepted with no step pulse.
